// File: rtl/clk_en_pkg.sv
// rtl/clk_en_pkg.sv - shared types, helpers and defaults for the clock-enable divider
package clk_en_pkg;

    // Per-channel FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    // Select-bus width for n channels, never narrower than one bit
    function automatic int clog2_min1(input int n);
        int r;
        r = (n <= 1) ? 1 : $clog2(n);
        return r;
    endfunction

    localparam int CHANNELS_NUM_DEF = 4;
    localparam int SEL_BITS_NUM     = clog2_min1(CHANNELS_NUM_DEF);

endpackage

// File: rtl/clk_en_channel.sv
// rtl/clk_en_channel.sv - one strobe channel: FSM, down-counter, ratio register, optional toggle (CLK_EN_DIV_SQUARE_EN)
module clk_en_channel
    import clk_en_pkg::*;
#(
    parameter int                    DIV_BITS_NUM = 17,
    parameter logic [DIV_BITS_NUM-1:0] DEFAULT_DIV  = '1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    run_i,
    input  logic                    div_we_i,
    input  logic [DIV_BITS_NUM-1:0] div_i,
`ifdef CLK_EN_DIV_SQUARE_EN
    output logic                    square_o,
`endif
    output logic                    clk_en_o
);

    state_e                  state_q, state_d;
    logic [DIV_BITS_NUM-1:0] counter_q, counter_d;
    logic [DIV_BITS_NUM-1:0] ratio_q, ratio_d;
    logic [DIV_BITS_NUM-1:0] reload_val;
    logic                    clk_en_q, clk_en_d;
    logic                    square_q, square_d;

    // Next-state logic; a ratio write in a reload cycle feeds straight into the reload
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        clk_en_d   = 1'b0;
        square_d   = square_q;
        reload_val = div_we_i ? div_i : ratio_q;
        ratio_d    = div_we_i ? div_i : ratio_q;
        case (state_q)
            IDLE: begin
                square_d = 1'b0;
                if (run_i) begin
                    counter_d = reload_val;
                    state_d   = COUNT;
                end
            end
            COUNT: begin
                if (!run_i) begin
                    state_d  = IDLE;
                    square_d = 1'b0;
                end else if (counter_q == '0) begin
                    counter_d = reload_val;
                    clk_en_d  = 1'b1;
                    square_d  = ~square_q;
                end else begin
                    counter_d = counter_q - DIV_BITS_NUM'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            counter_q <= '0;
            ratio_q   <= DEFAULT_DIV;
            clk_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            ratio_q   <= ratio_d;
            clk_en_q  <= clk_en_d;
        end
    end

    assign clk_en_o = clk_en_q;

`ifdef CLK_EN_DIV_SQUARE_EN
    // Toggle flop flipping on every strobe, giving a 50% duty square wave
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            square_q <= 1'b0;
        end else begin
            square_q <= square_d;
        end
    end

    assign square_o = square_q;
`else
    assign square_q = 1'b0;
`endif

endmodule

// File: rtl/clk_en_divider.sv
// rtl/clk_en_divider.sv - multi-channel programmable clock-enable generator (optional square_o via CLK_EN_DIV_SQUARE_EN)
module clk_en_divider
    import clk_en_pkg::*;
#(
    parameter int          CHANNELS_NUM = CHANNELS_NUM_DEF,
    parameter int          DIV_BITS_NUM = 17,
    parameter int unsigned DEFAULT_DIV  = 2**17 - 1,
    localparam int         SEL_W        = clog2_min1(CHANNELS_NUM)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [CHANNELS_NUM-1:0] run_i,
    input  logic                    div_we_i,
    input  logic [SEL_W-1:0]        div_sel_i,
    input  logic [DIV_BITS_NUM-1:0] div_i,
`ifdef CLK_EN_DIV_SQUARE_EN
    output logic [CHANNELS_NUM-1:0] square_o,
`endif
    output logic [CHANNELS_NUM-1:0] clk_en_o
);

    logic [CHANNELS_NUM-1:0] ch_we;

    // Decode the write select; indices with no matching channel write nothing
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < CHANNELS_NUM; i++) begin
            ch_we[i] = div_we_i && (div_sel_i == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS_NUM; g++) begin : g_ch
        clk_en_channel #(
            .DIV_BITS_NUM (DIV_BITS_NUM),
            .DEFAULT_DIV  (DIV_BITS_NUM'(DEFAULT_DIV))
        ) u_ch (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .run_i    (run_i[g]),
            .div_we_i (ch_we[g]),
            .div_i    (div_i),
`ifdef CLK_EN_DIV_SQUARE_EN
            .square_o (square_o[g]),
`endif
            .clk_en_o (clk_en_o[g])
        );
    end

endmodule
